jtcop_ba_resp: RTL and testbench

Responder side of the 4-bank SDRAM request interface used by the bank slot muxes: ba*_addr, ba_rd, ba_wr, ba_ack, ba_dst, ba_dok, ba_rdy and data_read. Arbitrates the four bank requesters round-robin and serves one transaction at a time on a simple fixed-latency memory port. Used as the SDRAM-controller stand-in for simulation and for BRAM-backed builds.

---
 rtl/jtcop_ba_resp.sv | 178 +++++++++++++++++
 tb/tb_jtcop_ba_resp.sv | 394 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jtcop_ba_resp.sv
`default_nettype none
// ============================================================================
// Module   : jtcop_ba_resp
// Purpose  : Round-robin responder for the 4-bank SDRAM request interface,
//            serving one transaction at a time on a fixed-latency memory port.
// Revision : 1.0
// ============================================================================
module jtcop_ba_resp #(
    parameter int AW      = 22,
    parameter int BURST   = 2,
    parameter int MEM_LAT = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] ba0_addr,
    input  logic [AW-1:0] ba1_addr,
    input  logic [AW-1:0] ba2_addr,
    input  logic [AW-1:0] ba3_addr,
    input  logic [3:0]    ba_rd,
    input  logic          ba_wr,
    input  logic [15:0]   ba0_din,
    input  logic [1:0]    ba0_din_m,
    output logic [3:0]    ba_ack,
    output logic [3:0]    ba_dst,
    output logic [3:0]    ba_dok,
    output logic [3:0]    ba_rdy,
    output logic [15:0]   data_read,
    output logic [AW+1:0] mem_addr,
    output logic          mem_rd,
    output logic          mem_wr,
    output logic [15:0]   mem_din,
    output logic [1:0]    mem_wrmask,
    input  logic [15:0]   mem_dout
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_READ  = 2'd1;
    localparam logic [1:0] S_WRITE = 2'd2;
    localparam logic [1:0] S_WAIT  = 2'd3;

    logic [1:0]         state_q, state_d;
    logic [1:0]         ptr_q, ptr_d, bank_q, bank_d, gnt, idx;
    logic               gnt_vld, start;
    logic [3:0]         req, bank_oh;
    logic [AW-1:0]      addr_q, addr_d;
    logic [15:0]        din_q, din_d, data_q, data_d;
    logic [1:0]         mask_q, mask_d;
    logic [2:0]         cnt_q, cnt_d;
    logic [3:0]         ack_q, ack_d, dst_q, dst_d, dok_q, dok_d, rdy_q, rdy_d;
    logic [MEM_LAT-1:0] tv_q, tv_d, tf_q, tf_d, tl_q, tl_d;

    assign req     = {ba_rd[3:1], ba_rd[0] | ba_wr};
    assign bank_oh = 4'b0001 << bank_q;
    assign start   = (state_q == S_IDLE) && gnt_vld;

    // First requester above the last winner gets the slot
    always_comb begin
        gnt     = '0;
        gnt_vld = 1'b0;
        idx     = '0;
        for (int i = 1; i <= 4; i++) begin
            idx = ptr_q + 2'(i);
            if (!gnt_vld && req[idx]) begin
                gnt_vld = 1'b1;
                gnt     = idx;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (gnt_vld) state_d = (gnt == 2'd0 && ba_wr) ? S_WRITE : S_READ;
            S_READ:  if (|rdy_q)  state_d = S_IDLE;
            S_WRITE: state_d = S_WAIT;
            S_WAIT:  if (|rdy_q)  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        mem_rd     = (state_q == S_READ) && (cnt_q < 3'(BURST));
        mem_wr     = (state_q == S_WRITE);
        mem_addr   = (mem_rd || mem_wr) ? {bank_q, addr_q + AW'(cnt_q)} : '0;
        mem_din    = mem_wr ? din_q  : '0;
        mem_wrmask = mem_wr ? mask_q : '0;
    end

    always_comb begin
        ptr_d  = ptr_q;
        bank_d = bank_q;
        addr_d = addr_q;
        din_d  = din_q;
        mask_d = mask_q;
        cnt_d  = cnt_q;
        ack_d  = '0;
        if (start) begin
            ptr_d  = gnt;
            bank_d = gnt;
            din_d  = ba0_din;
            mask_d = ba0_din_m;
            cnt_d  = '0;
            ack_d  = 4'b0001 << gnt;
            case (gnt)
                2'd0:    addr_d = ba0_addr;
                2'd1:    addr_d = ba1_addr;
                2'd2:    addr_d = ba2_addr;
                default: addr_d = ba3_addr;
            endcase
        end else if (mem_rd) begin
            cnt_d = cnt_q + 3'd1;
        end
    end

    // Return tags ride alongside each read so the output stage knows first/last
    always_comb begin
        tv_d[0] = mem_rd;
        tf_d[0] = (cnt_q == 3'd0);
        tl_d[0] = (cnt_q == 3'(BURST - 1));
        for (int i = 1; i < MEM_LAT; i++) begin
            tv_d[i] = tv_q[i-1];
            tf_d[i] = tf_q[i-1];
            tl_d[i] = tl_q[i-1];
        end
        dok_d  = tv_q[MEM_LAT-1] ? bank_oh : 4'b0000;
        dst_d  = (tv_q[MEM_LAT-1] && tf_q[MEM_LAT-1]) ? bank_oh : 4'b0000;
        rdy_d  = (tv_q[MEM_LAT-1] && tl_q[MEM_LAT-1]) ? bank_oh :
                 (state_q == S_WRITE)                ? 4'b0001 : 4'b0000;
        data_d = tv_q[MEM_LAT-1] ? mem_dout : data_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q  <= 2'd3;
            bank_q <= '0;
            addr_q <= '0;
            din_q  <= '0;
            mask_q <= '0;
            cnt_q  <= '0;
            ack_q  <= '0;
            dst_q  <= '0;
            dok_q  <= '0;
            rdy_q  <= '0;
            data_q <= '0;
            tv_q   <= '0;
            tf_q   <= '0;
            tl_q   <= '0;
        end else begin
            ptr_q  <= ptr_d;
            bank_q <= bank_d;
            addr_q <= addr_d;
            din_q  <= din_d;
            mask_q <= mask_d;
            cnt_q  <= cnt_d;
            ack_q  <= ack_d;
            dst_q  <= dst_d;
            dok_q  <= dok_d;
            rdy_q  <= rdy_d;
            data_q <= data_d;
            tv_q   <= tv_d;
            tf_q   <= tf_d;
            tl_q   <= tl_d;
        end
    end

    assign ba_ack    = ack_q;
    assign ba_dst    = dst_q;
    assign ba_dok    = dok_q;
    assign ba_rdy    = rdy_q;
    assign data_read = data_q;

endmodule
`default_nettype wire

// File: tb/tb_jtcop_ba_resp.sv
`default_nettype none
// ============================================================================
// Module   : tb_jtcop_ba_resp
// Purpose  : Self-checking bench; three responder configurations share stimulus.
// Revision : 1.0
// ============================================================================
module tb_jtcop_ba_resp;

    logic        clk = 1'b0;
    logic        rst;
    logic [21:0] a0, a1, a2, a3;
    logic [3:0]  rd;
    logic        wr;
    logic [15:0] din;
    logic [1:0]  dinm;

    always #5 clk = ~clk;

    // a: BURST=2 MEM_LAT=2, b: BURST=1 MEM_LAT=1, c: BURST=4 MEM_LAT=2
    logic [3:0]  a_ack, a_dst, a_dok, a_rdy, b_ack, b_dst, b_dok, b_rdy, c_ack, c_dst, c_dok, c_rdy;
    logic [15:0] a_data, b_data, c_data, a_mdin, b_mdin, c_mdin, a_mdout, b_mdout, c_mdout;
    logic [23:0] a_maddr, b_maddr, c_maddr;
    logic        a_mrd, a_mwr, b_mrd, b_mwr, c_mrd, c_mwr;
    logic [1:0]  a_mmask, b_mmask, c_mmask;
    logic [15:0] a_p0, a_p1, b_p0, c_p0, c_p1;

    jtcop_ba_resp #(.AW(22), .BURST(2), .MEM_LAT(2)) u_a (
        .clk(clk), .rst(rst), .ba0_addr(a0), .ba1_addr(a1), .ba2_addr(a2), .ba3_addr(a3),
        .ba_rd(rd), .ba_wr(wr), .ba0_din(din), .ba0_din_m(dinm),
        .ba_ack(a_ack), .ba_dst(a_dst), .ba_dok(a_dok), .ba_rdy(a_rdy), .data_read(a_data),
        .mem_addr(a_maddr), .mem_rd(a_mrd), .mem_wr(a_mwr), .mem_din(a_mdin),
        .mem_wrmask(a_mmask), .mem_dout(a_mdout));

    jtcop_ba_resp #(.AW(22), .BURST(1), .MEM_LAT(1)) u_b (
        .clk(clk), .rst(rst), .ba0_addr(a0), .ba1_addr(a1), .ba2_addr(a2), .ba3_addr(a3),
        .ba_rd(rd), .ba_wr(wr), .ba0_din(din), .ba0_din_m(dinm),
        .ba_ack(b_ack), .ba_dst(b_dst), .ba_dok(b_dok), .ba_rdy(b_rdy), .data_read(b_data),
        .mem_addr(b_maddr), .mem_rd(b_mrd), .mem_wr(b_mwr), .mem_din(b_mdin),
        .mem_wrmask(b_mmask), .mem_dout(b_mdout));

    jtcop_ba_resp #(.AW(22), .BURST(4), .MEM_LAT(2)) u_c (
        .clk(clk), .rst(rst), .ba0_addr(a0), .ba1_addr(a1), .ba2_addr(a2), .ba3_addr(a3),
        .ba_rd(rd), .ba_wr(wr), .ba0_din(din), .ba0_din_m(dinm),
        .ba_ack(c_ack), .ba_dst(c_dst), .ba_dok(c_dok), .ba_rdy(c_rdy), .data_read(c_data),
        .mem_addr(c_maddr), .mem_rd(c_mrd), .mem_wr(c_mwr), .mem_din(c_mdin),
        .mem_wrmask(c_mmask), .mem_dout(c_mdout));

    // Memory model: data word = low 16 bits of the address, MEM_LAT cycles later
    always @(posedge clk) begin
        a_p0 <= a_maddr[15:0];
        a_p1 <= a_p0;
        b_p0 <= b_maddr[15:0];
        c_p0 <= c_maddr[15:0];
        c_p1 <= c_p0;
    end
    assign a_mdout = a_p1;
    assign b_mdout = b_p0;
    assign c_mdout = c_p1;

    typedef struct {
        int          bank;
        logic [15:0] d;
        bit          dst;
        bit          rdy;
    } exp_t;

    exp_t qa[$];
    exp_t qc[$];
    bit   c_en = 1'b0;
    int   total = 0;
    int   bad = 0;

    function automatic logic [3:0] oh(input int b);
        return 4'b0001 << b;
    endfunction

    task automatic monitor_a();
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && a_dok != 4'b0) begin
                total++;
                if (qa.size() == 0) begin
                    bad++;
                    $display("FAIL a_unexpected_dok dok=%b data=%h required no word", a_dok, a_data);
                end else begin
                    e = qa.pop_front();
                    if (a_dok !== oh(e.bank) || a_dst !== (e.dst ? oh(e.bank) : 4'b0) ||
                        a_rdy !== (e.rdy ? oh(e.bank) : 4'b0) || a_data !== e.d) begin
                        bad++;
                        $display("FAIL a_word got dok=%b dst=%b rdy=%b data=%h required bank=%0d dst=%0d rdy=%0d data=%h",
                                 a_dok, a_dst, a_rdy, a_data, e.bank, e.dst, e.rdy, e.d);
                    end
                end
            end
        end
    endtask

    task automatic monitor_c();
        exp_t e;
        forever begin
            @(negedge clk);
            if (c_en && !rst && c_dok != 4'b0) begin
                total++;
                if (qc.size() == 0) begin
                    bad++;
                    $display("FAIL c_unexpected_dok dok=%b data=%h required no word", c_dok, c_data);
                end else begin
                    e = qc.pop_front();
                    if (c_dok !== oh(e.bank) || c_dst !== (e.dst ? oh(e.bank) : 4'b0) ||
                        c_rdy !== (e.rdy ? oh(e.bank) : 4'b0) || c_data !== e.d) begin
                        bad++;
                        $display("FAIL c_word got dok=%b dst=%b rdy=%b data=%h required bank=%0d dst=%0d rdy=%0d data=%h",
                                 c_dok, c_dst, c_rdy, c_data, e.bank, e.dst, e.rdy, e.d);
                    end
                end
            end
        end
    endtask

    // Holds each mask bit until unit a acks it; reports the observed ack order
    task automatic serve(input logic [3:0] m, output int ord[4], output int n);
        logic [3:0] drop;
        n = 0;
        for (int i = 0; i < 4; i++) ord[i] = -1;
        @(posedge clk); #1;
        rd = m;
        for (int c = 0; c < 80 && rd != 4'b0; c++) begin
            @(negedge clk);
            drop = a_ack & rd;
            for (int b = 0; b < 4; b++)
                if (a_ack[b] && n < 4) begin
                    ord[n] = b;
                    n++;
                end
            @(posedge clk); #1;
            rd = rd & ~drop;
        end
        rd = 4'b0;
        repeat (12) @(posedge clk);
    endtask

    task automatic pulse_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        total++;
        if ({a_ack, a_dst, a_dok, a_rdy, a_data, a_maddr, a_mrd, a_mwr, a_mdin, a_mmask} !== '0) begin
            bad++;
            $display("FAIL reset_outputs ack=%b dok=%b rdy=%b data=%h maddr=%h rd=%b wr=%b required all zero",
                     a_ack, a_dok, a_rdy, a_data, a_maddr, a_mrd, a_mwr);
        end
        @(posedge clk); #1 rst = 1'b0;
    endtask

    task automatic test_single_read();
        @(posedge clk); #1;
        a2 = 22'h1000;
        rd = 4'b0100;
        qa.push_back('{2, 16'h1000, 1'b1, 1'b0});
        qa.push_back('{2, 16'h1001, 1'b0, 1'b1});
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            total++;
            case (c)
                0: if (a_ack !== 4'b0) begin bad++; $display("FAIL rd_ack_early ack=%b required 0000", a_ack); end
                1: if (a_ack !== 4'b0100 || a_mrd !== 1'b1 || a_maddr !== 24'h801000) begin
                       bad++; $display("FAIL rd_cyc1 ack=%b mem_rd=%b addr=%h required 0100 1 801000", a_ack, a_mrd, a_maddr); end
                2: if (a_ack !== 4'b0 || a_mrd !== 1'b1 || a_maddr !== 24'h801001) begin
                       bad++; $display("FAIL rd_cyc2 ack=%b mem_rd=%b addr=%h required 0000 1 801001", a_ack, a_mrd, a_maddr); end
                3: if (a_mrd !== 1'b0 || a_dok !== 4'b0) begin
                       bad++; $display("FAIL rd_cyc3 mem_rd=%b dok=%b required 0 0000", a_mrd, a_dok); end
                4: if (a_dst !== 4'b0100 || a_dok !== 4'b0100 || a_data !== 16'h1000) begin
                       bad++; $display("FAIL rd_cyc4 dst=%b dok=%b data=%h required 0100 0100 1000", a_dst, a_dok, a_data); end
                5: if (a_rdy !== 4'b0100 || a_dst !== 4'b0 || a_data !== 16'h1001) begin
                       bad++; $display("FAIL rd_cyc5 rdy=%b dst=%b data=%h required 0100 0000 1001", a_rdy, a_dst, a_data); end
                default: if (a_dok !== 4'b0 || a_data !== 16'h1001) begin
                       bad++; $display("FAIL rd_hold dok=%b data=%h required 0000 1001", a_dok, a_data); end
            endcase
            @(posedge clk); #1;
            if (c == 1) rd = 4'b0;
        end
        repeat (6) @(posedge clk);
    endtask

    task automatic test_write();
        logic [3:0] seen;
        seen = 4'b0;
        @(posedge clk); #1;
        a0 = 22'h10_0004; din = 16'hA55A; dinm = 2'b10;
        wr = 1'b1; rd = 4'b0001;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            seen = seen | a_dst | a_dok;
            if (c == 1) begin
                total++;
                if (a_mwr !== 1'b1 || a_mrd !== 1'b0 || a_ack !== 4'b0001 || a_mmask !== 2'b10 ||
                    a_mdin !== 16'hA55A || a_maddr !== 24'h10_0004) begin
                    bad++;
                    $display("FAIL wr_cyc1 wr=%b rd=%b ack=%b mask=%b din=%h addr=%h required 1 0 0001 10 a55a 100004",
                             a_mwr, a_mrd, a_ack, a_mmask, a_mdin, a_maddr);
                end
            end
            if (c == 2) begin
                total++;
                if (a_rdy !== 4'b0001 || a_mwr !== 1'b0) begin
                    bad++; $display("FAIL wr_cyc2 rdy=%b wr=%b required 0001 0", a_rdy, a_mwr);
                end
            end
            @(posedge clk); #1;
            if (c == 1) begin wr = 1'b0; rd = 4'b0; end
        end
        total++;
        if (seen !== 4'b0) begin bad++; $display("FAIL wr_no_data dst|dok=%b required 0000", seen); end
        repeat (6) @(posedge clk);
    endtask

    task automatic test_contention();
        int ord[4];
        int n;
        pulse_reset();
        a0 = 22'h0; a1 = 22'h10; a2 = 22'h20; a3 = 22'h30;
        for (int b = 0; b < 4; b++) begin
            qa.push_back('{b, 16'(b * 16), 1'b1, 1'b0});
            qa.push_back('{b, 16'(b * 16 + 1), 1'b0, 1'b1});
        end
        serve(4'hF, ord, n);
        total++;
        if (n != 4 || ord[0] != 0 || ord[1] != 1 || ord[2] != 2 || ord[3] != 3) begin
            bad++; $display("FAIL rr_all order=%0d,%0d,%0d,%0d n=%0d required 0,1,2,3 n=4", ord[0], ord[1], ord[2], ord[3], n);
        end
        qa.push_back('{1, 16'h0010, 1'b1, 1'b0});
        qa.push_back('{1, 16'h0011, 1'b0, 1'b1});
        serve(4'b0010, ord, n);
        total++;
        if (n != 1 || ord[0] != 1) begin
            bad++; $display("FAIL rr_b1 order=%0d n=%0d required 1 n=1", ord[0], n);
        end
        qa.push_back('{3, 16'h0030, 1'b1, 1'b0});
        qa.push_back('{3, 16'h0031, 1'b0, 1'b1});
        qa.push_back('{1, 16'h0010, 1'b1, 1'b0});
        qa.push_back('{1, 16'h0011, 1'b0, 1'b1});
        serve(4'b1010, ord, n);
        total++;
        if (n != 2 || ord[0] != 3 || ord[1] != 1) begin
            bad++; $display("FAIL rr_13 order=%0d,%0d n=%0d required 3,1 n=2", ord[0], ord[1], n);
        end
    endtask

    task automatic test_reset_mid();
        int  ord[4];
        int  n;
        bit  acked;
        logic [3:0] seen;
        acked = 1'b0;
        seen  = 4'b0;
        @(posedge clk); #1;
        a1 = 22'h55;
        rd = 4'b0010;
        for (int c = 0; c < 10 && !acked; c++) begin
            @(negedge clk);
            if (a_ack[1]) acked = 1'b1;
        end
        total++;
        if (!acked) begin bad++; $display("FAIL rst_mid_ack ack=%b required bank1 ack within 10 cycles", a_ack); end
        @(posedge clk); #1;
        rd = 4'b0;
        rst = 1'b1;
        #1;
        total++;
        if ({a_ack, a_dst, a_dok, a_rdy, a_data, a_maddr, a_mrd, a_mwr, a_mdin, a_mmask} !== '0) begin
            bad++;
            $display("FAIL rst_mid_outputs ack=%b dok=%b rdy=%b data=%h maddr=%h rd=%b required all zero",
                     a_ack, a_dok, a_rdy, a_data, a_maddr, a_mrd);
        end
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            seen = seen | a_dst | a_dok | a_rdy;
        end
        total++;
        if (seen !== 4'b0) begin bad++; $display("FAIL rst_mid_silent dst|dok|rdy=%b required 0000", seen); end
        a0 = 22'h0; a2 = 22'h20;
        qa.push_back('{0, 16'h0000, 1'b1, 1'b0});
        qa.push_back('{0, 16'h0001, 1'b0, 1'b1});
        qa.push_back('{2, 16'h0020, 1'b1, 1'b0});
        qa.push_back('{2, 16'h0021, 1'b0, 1'b1});
        serve(4'b0101, ord, n);
        total++;
        if (n != 2 || ord[0] != 0 || ord[1] != 2) begin
            bad++; $display("FAIL rst_mid_ptr order=%0d,%0d n=%0d required 0,2 n=2", ord[0], ord[1], n);
        end
    endtask

    task automatic test_burst1();
        @(posedge clk); #1;
        a3 = 22'h3F_FFFF;
        rd = 4'b1000;
        qa.push_back('{3, 16'hFFFF, 1'b1, 1'b0});
        qa.push_back('{3, 16'h0000, 1'b0, 1'b1});
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (c == 1) begin
                total++;
                if (b_ack !== 4'b1000 || b_mrd !== 1'b1 || b_maddr !== 24'hFF_FFFF) begin
                    bad++; $display("FAIL b1_cyc1 ack=%b mem_rd=%b addr=%h required 1000 1 ffffff", b_ack, b_mrd, b_maddr);
                end
            end
            if (c == 2) begin
                total++;
                if (b_mrd !== 1'b0 || b_dok !== 4'b0) begin
                    bad++; $display("FAIL b1_cyc2 mem_rd=%b dok=%b required 0 0000", b_mrd, b_dok);
                end
            end
            if (c == 3) begin
                total++;
                if (b_dst !== 4'b1000 || b_dok !== 4'b1000 || b_rdy !== 4'b1000 || b_data !== 16'hFFFF) begin
                    bad++; $display("FAIL b1_cyc3 dst=%b dok=%b rdy=%b data=%h required 1000 1000 1000 ffff",
                                    b_dst, b_dok, b_rdy, b_data);
                end
            end
            @(posedge clk); #1;
            if (c == 1) rd = 4'b0;
        end
        repeat (8) @(posedge clk);
    endtask

    task automatic test_wrap();
        logic [21:0] seq [4];
        int k;
        seq[0] = 22'h3F_FFFE; seq[1] = 22'h3F_FFFF; seq[2] = 22'h00_0000; seq[3] = 22'h00_0001;
        k = 0;
        @(posedge clk); #1;
        c_en = 1'b1;
        a1 = 22'h3F_FFFE;
        rd = 4'b0010;
        qa.push_back('{1, 16'hFFFE, 1'b1, 1'b0});
        qa.push_back('{1, 16'hFFFF, 1'b0, 1'b1});
        qc.push_back('{1, 16'hFFFE, 1'b1, 1'b0});
        qc.push_back('{1, 16'hFFFF, 1'b0, 1'b0});
        qc.push_back('{1, 16'h0000, 1'b0, 1'b0});
        qc.push_back('{1, 16'h0001, 1'b0, 1'b1});
        for (int c = 0; c < 14; c++) begin
            @(negedge clk);
            if (c_mrd && k < 4) begin
                total++;
                if (c_maddr !== {2'b01, seq[k]}) begin
                    bad++; $display("FAIL wrap_addr%0d addr=%h required %h", k, c_maddr, {2'b01, seq[k]});
                end
                k++;
            end
            @(posedge clk); #1;
            if (c == 1) rd = 4'b0;
        end
        total++;
        if (k != 4 || qc.size() != 0) begin
            bad++; $display("FAIL wrap_count reads=%0d pending_words=%0d required 4 0", k, qc.size());
        end
        c_en = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        rd = 4'b0; wr = 1'b0; din = '0; dinm = '0;
        a0 = '0; a1 = '0; a2 = '0; a3 = '0;
        fork
            monitor_a();
            monitor_c();
        join_none
        test_reset();
        test_single_read();
        test_write();
        test_contention();
        test_reset_mid();
        test_burst1();
        test_wrap();
        repeat (4) @(posedge clk);
        total++;
        if (qa.size() != 0) begin
            bad++; $display("FAIL a_pending pending_words=%0d required 0", qa.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
